// File: rtl/radix32_pkg.sv
// Shared types and constants for the Radix_32 datapath controller.
package radix32_pkg;

  localparam int unsigned LAT_DEF   = 11;
  localparam int unsigned FRAME_LEN = 3;
  localparam int unsigned T_W       = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Registered control word driven onto the datapath.
  typedef struct packed {
    logic sel;
    logic sel1;
    logic sel2;
    logic sel4;
    logic sel5;
    logic sel6;
    logic sel7;
    logic acc_clr;
    logic en;
    logic in_ready;
    logic out_valid;
    logic busy;
    logic done;
  } ctrl_t;

endpackage

// File: rtl/radix32_phase_gen.sv
// Wrapping mod-2/3/6 phase counters tracking the run counter; exposes next-cycle phases.
module radix32_phase_gen
  import radix32_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       adv,
  output logic       ph2_c,
  output logic [1:0] ph3_c,
  output logic [2:0] ph6_c
);

  logic       ph2_q;
  logic [1:0] ph3_q;
  logic [2:0] ph6_q;

  // Next phase: clear on run start, advance one step per run cycle.
  always_comb begin
    ph2_c = ph2_q;
    ph3_c = ph3_q;
    ph6_c = ph6_q;
    if (clr) begin
      ph2_c = 1'b0;
      ph3_c = 2'd0;
      ph6_c = 3'd0;
    end else if (adv) begin
      ph2_c = ~ph2_q;
      ph3_c = (ph3_q == 2'd2) ? 2'd0 : ph3_q + 2'd1;
      ph6_c = (ph6_q == 3'd5) ? 3'd0 : ph6_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph2_q <= 1'b0;
      ph3_q <= 2'd0;
      ph6_q <= 3'd0;
    end else begin
      ph2_q <= ph2_c;
      ph3_q <= ph3_c;
      ph6_q <= ph6_c;
    end
  end

endmodule

// File: rtl/radix32_ctrl.sv
// Run controller for the Radix_32 datapath: sequences mux selects, enables and handshakes per run.
module radix32_ctrl
  import radix32_pkg::*;
#(
  parameter int unsigned LAT = LAT_DEF,
  parameter int unsigned FW  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [FW-1:0] frames,
  input  logic          abort,
  output logic          sel,
  output logic          sel1,
  output logic          sel2,
  output logic          sel4,
  output logic          sel5,
  output logic          sel6,
  output logic          sel7,
  output logic          acc_clr,
  output logic          en,
  output logic          in_ready,
  output logic          out_valid,
  output logic          busy,
  output logic          done
);

  localparam int unsigned CW = (((FW + 2) > T_W) ? (FW + 2) : T_W) + 1;

  state_t         state_q, state_n;
  logic [T_W-1:0] t_q, t_n;
  logic [FW-1:0]  frames_q, frames_n;
  ctrl_t          out_q, out_n;

  logic           accept;
  logic           adv;
  logic           ph2_c;
  logic [1:0]     ph3_c;
  logic [2:0]     ph6_c;
  logic [CW-1:0]  last_t;
  logic [CW-1:0]  in_end;
  logic [CW-1:0]  out_end;
  logic [CW-1:0]  t_n_w;

  assign accept   = (state_q == ST_IDLE) && start && (frames != '0);
  assign adv      = (state_q == ST_RUN);
  assign frames_n = accept ? frames : frames_q;

  // Window bounds: last_t for the running frame count, in/out ends for the next cycle's decode.
  assign last_t  = CW'(frames_q) * CW'(FRAME_LEN) + CW'(LAT) - CW'(1);
  assign in_end  = CW'(frames_n) * CW'(FRAME_LEN);
  assign out_end = in_end + CW'(LAT);
  assign t_n_w   = CW'(t_n);

  radix32_phase_gen u_phase (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .adv   (adv),
    .ph2_c (ph2_c),
    .ph3_c (ph3_c),
    .ph6_c (ph6_c)
  );

  // Next state, next run counter and the control word for the coming cycle.
  always_comb begin
    state_n = state_q;
    t_n     = t_q;
    out_n   = '0;

    case (state_q)
      ST_IDLE: begin
        t_n = '0;
        if (accept) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (abort) begin
          state_n = ST_IDLE;
          t_n     = '0;
        end else begin
          t_n = t_q + T_W'(1);
          if (CW'(t_q) == last_t) state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        t_n     = '0;
      end
      default: begin
        state_n = ST_IDLE;
        t_n     = '0;
      end
    endcase

    // Phase-based selects; offsets of the delayed selects folded into the mod-3/mod-6 phase.
    if (state_n == ST_RUN) begin
      out_n.sel1      = ph2_c;
      out_n.sel5      = (ph3_c != 2'd1);
      out_n.sel6      = (ph3_c == 2'd0);
      out_n.sel4      = (t_n >= T_W'(4)) && (ph6_c >= 3'd1) && (ph6_c <= 3'd3);
      out_n.sel       = (t_n >= T_W'(5)) && (ph3_c != 2'd2);
      out_n.sel2      = (t_n >= T_W'(7)) && (ph3_c != 2'd1);
      out_n.sel7      = (t_n >= T_W'(8)) && ((ph6_c <= 3'd1) || (ph6_c == 3'd5));
      out_n.in_ready  = (t_n_w < in_end);
      out_n.en        = (t_n >= T_W'(LAT));
      out_n.acc_clr   = (t_n >= T_W'(LAT)) && (ph3_c == 2'(LAT % 3));
      out_n.out_valid = (t_n >= T_W'(LAT)) && (t_n_w < out_end);
    end
    out_n.busy = (state_n != ST_IDLE);
    out_n.done = (state_n == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      t_q      <= '0;
      frames_q <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_n;
      t_q      <= t_n;
      frames_q <= frames_n;
      out_q    <= out_n;
    end
  end

  assign sel       = out_q.sel;
  assign sel1      = out_q.sel1;
  assign sel2      = out_q.sel2;
  assign sel4      = out_q.sel4;
  assign sel5      = out_q.sel5;
  assign sel6      = out_q.sel6;
  assign sel7      = out_q.sel7;
  assign acc_clr   = out_q.acc_clr;
  assign en        = out_q.en;
  assign in_ready  = out_q.in_ready;
  assign out_valid = out_q.out_valid;
  assign busy      = out_q.busy;
  assign done      = out_q.done;

endmodule

// File: tb/tb_radix32_ctrl.sv
// Self-checking bench for radix32_ctrl against a run-level arithmetic reference model.
module tb_radix32_ctrl;

  localparam int LAT = 11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] frames = 8'd0;
  logic sel, sel1, sel2, sel4, sel5, sel6, sel7;
  logic acc_clr, en, in_ready, out_valid, busy, done;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 idle, 1 run, 2 done; t is the run counter, f the latched frame count.
  int m_mode = 0;
  int m_t = 0;
  int m_f = 0;

  radix32_ctrl #(.LAT(LAT), .FW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frames(frames), .abort(abort),
    .sel(sel), .sel1(sel1), .sel2(sel2), .sel4(sel4), .sel5(sel5), .sel6(sel6), .sel7(sel7),
    .acc_clr(acc_clr), .en(en), .in_ready(in_ready), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] model_out();
    logic e_sel, e_sel1, e_sel2, e_sel4, e_sel5, e_sel6, e_sel7;
    logic e_clr, e_en, e_rdy, e_vld;
    int t;
    t = m_t;
    {e_sel, e_sel1, e_sel2, e_sel4, e_sel5, e_sel6, e_sel7, e_clr, e_en, e_rdy, e_vld} = '0;
    if (m_mode == 1) begin
      e_sel1 = (t % 2) == 1;
      e_sel5 = (t % 3) == 0 || (t % 3) == 2;
      e_sel6 = (t % 3) == 0;
      e_sel4 = t >= 4 && ((t - 4) % 6) >= 3;
      e_sel  = t >= 5 && ((t - 5) % 3) != 0;
      e_sel2 = t >= 7 && ((t - 7) % 3) != 0;
      e_sel7 = t >= 8 && ((t - 8) % 6) >= 3;
      e_rdy  = t < 3 * m_f;
      e_en   = t >= LAT;
      e_clr  = t >= LAT && ((t - LAT) % 3) == 0;
      e_vld  = t >= LAT && t < LAT + 3 * m_f;
    end
    return {e_sel, e_sel1, e_sel2, e_sel4, e_sel5, e_sel6, e_sel7, e_clr, e_en, e_rdy, e_vld,
            1'(m_mode != 0), 1'(m_mode == 2)};
  endfunction

  function automatic logic [12:0] dut_out();
    return {sel, sel1, sel2, sel4, sel5, sel6, sel7, acc_clr, en, in_ready, out_valid, busy, done};
  endfunction

  // One clock: model consumes the inputs present at the edge; returns 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      m_mode = 0; m_t = 0;
    end else begin
      case (m_mode)
        0: if (start && frames != 0) begin m_mode = 1; m_t = 0; m_f = int'(frames); end
        1: begin
          if (abort) begin m_mode = 0; m_t = 0; end
          else if (m_t == LAT + 3 * m_f - 1) begin m_mode = 2; m_t = m_t + 1; end
          else m_t = m_t + 1;
        end
        default: begin m_mode = 0; m_t = 0; end
      endcase
    end
    #1;
  endtask

  task automatic drain();
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 200 && m_mode != 0; i++) step();
    step();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_out() !== 13'd0) begin
      errors++; $display("FAIL reset_async got=%b exp=%b", dut_out(), 13'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut_out() !== model_out()) begin
        errors++; $display("FAIL reset_hold got=%b exp=%b", dut_out(), model_out());
      end
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_frame();
    int done_at = -1;
    frames = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      checks++;
      if (dut_out() !== model_out()) begin
        errors++; $display("FAIL single t=%0d got=%b exp=%b", n, dut_out(), model_out());
      end
      if (done) begin done_at = n; break; end
      step();
    end
    checks++;
    if (done_at != 14) begin
      errors++; $display("FAIL single_done_t got=%0d exp=14", done_at);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single_busy_after got=%b exp=0", busy);
    end
  endtask

  task automatic test_frames4_pattern();
    int clr_cnt = 0;
    frames = 8'd4; start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 40 && m_mode != 0; n++) begin
      checks++;
      if (dut_out() !== model_out()) begin
        errors++; $display("FAIL frames4 t=%0d got=%b exp=%b", m_t, dut_out(), model_out());
      end
      if (acc_clr) clr_cnt++;
      step();
    end
    checks++;
    if (clr_cnt != 4) begin
      errors++; $display("FAIL frames4_acc_clr_count got=%0d exp=4", clr_cnt);
    end
    drain();
  endtask

  task automatic test_zero_frames();
    frames = 8'd0; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (dut_out() !== 13'd0) begin
        errors++; $display("FAIL zero_frames got=%b exp=%b", dut_out(), 13'd0);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_abort();
    int seen_done = 0;
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut_out() !== 13'd0) begin
        errors++; $display("FAIL abort_idle got=%b exp=%b", dut_out(), 13'd0);
      end
    end
    abort = 1'b0; frames = 8'd4; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && m_t != 6; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (dut_out() !== 13'd0 || m_mode != 0) begin
      errors++; $display("FAIL abort_t6 got=%b exp=%b", dut_out(), 13'd0);
    end
    for (int i = 0; i < 25; i++) begin
      step();
      if (done) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++; $display("FAIL abort_no_done got=%0d exp=0", seen_done);
    end
  endtask

  task automatic test_reset_midrun();
    int done_at = -1;
    frames = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && m_t != 7; i++) step();
    #2 rst_n = 1'b0;
    m_mode = 0; m_t = 0;
    #1;
    checks++;
    if (dut_out() !== 13'd0) begin
      errors++; $display("FAIL reset_midrun got=%b exp=%b", dut_out(), 13'd0);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    frames = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      checks++;
      if (dut_out() !== model_out()) begin
        errors++; $display("FAIL restart t=%0d got=%b exp=%b", n, dut_out(), model_out());
      end
      if (done) begin done_at = n; break; end
      step();
    end
    checks++;
    if (done_at != 17) begin
      errors++; $display("FAIL restart_done_t got=%0d exp=17", done_at);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int runs = 0;
    frames = 8'd1; start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (dut_out() !== model_out()) begin
        errors++; $display("FAIL b2b cyc=%0d got=%b exp=%b", i, dut_out(), model_out());
      end
      if (done) begin
        runs++;
        step();
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL b2b_idle_gap got=%b exp=0", busy);
        end
        step();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
          errors++; $display("FAIL b2b_restart got=%b%b exp=11", in_ready, busy);
        end
      end
    end
    checks++;
    if (runs < 2) begin
      errors++; $display("FAIL b2b_runs got=%0d exp>=2", runs);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      start  = ($urandom % 4) == 0;
      frames = 8'($urandom_range(0, 5));
      abort  = ($urandom % 40) == 0;
      step();
      checks++;
      if (dut_out() !== model_out()) begin
        errors++; $display("FAIL random cyc=%0d t=%0d got=%b exp=%b", i, m_t, dut_out(), model_out());
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_frames4_pattern();
    test_zero_frames();
    test_abort();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
